// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, decode and register-read stages.
// The master side is the stage's environment; the slave side is the decode stage.
interface rv_decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic             rd_we;
  logic             illegal;
  logic [CNT_W-1:0] decode_count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, func3, func7, rs1, rs2, rd, imm, fmt,
           mem_size, mem_unsigned, rd_we, illegal, decode_count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, func3, func7, rs1, rs2, rd, imm, fmt,
           mem_size, mem_unsigned, rd_we, illegal, decode_count
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: one registered output bundle plus one skid entry, so the stage
// sustains one instruction per cycle while absorbing a single cycle of back-pressure.
module rv_decode_stage #(
  parameter int unsigned XLEN        = 32,
  parameter bit          ENABLE_MEXT = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  rv_decode_stage_if.slave dec_if
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] FmtR    = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtNone = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            rd_we;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    dec_t       d;
    logic       legal;
    logic [2:0] f3;
    logic [6:0] f7;
    f3       = instr[14:12];
    f7       = instr[31:25];
    d        = '0;
    d.opcode = instr[6:0];
    d.pc     = pc;
    // Every immediate format keeps its sign in instr[31]; low bits are overlaid per format.
    d.imm    = {XLEN{instr[31]}};
    legal    = 1'b0;
    case (instr[6:0])
      OpR: begin
        legal   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                  (ENABLE_MEXT && f7 == 7'h01);
        d.fmt   = FmtR;
        d.func3 = f3;
        d.func7 = f7;
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.rd    = instr[11:7];
        d.rd_we = 1'b1;
        d.imm   = '0;
      end
      OpI, OpLoad, OpJalr: begin
        if (instr[6:0] == OpLoad) begin
          legal          = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
          d.mem_size     = f3[1:0];
          d.mem_unsigned = f3[2];
        end else if (instr[6:0] == OpJalr) begin
          legal = (f3 == 3'b000);
        end else begin
          legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        end
        d.fmt        = FmtI;
        d.func3      = f3;
        d.rs1        = instr[19:15];
        d.rd         = instr[11:7];
        d.rd_we      = 1'b1;
        d.imm[11:0]  = instr[31:20];
      end
      OpStore: begin
        legal       = (f3 < 3'b011);
        d.fmt       = FmtS;
        d.func3     = f3;
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.mem_size  = f3[1:0];
        d.imm[11:0] = {instr[31:25], instr[11:7]};
      end
      OpBranch: begin
        legal       = !(f3 == 3'b010 || f3 == 3'b011);
        d.fmt       = FmtB;
        d.func3     = f3;
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OpJal: begin
        legal       = 1'b1;
        d.fmt       = FmtJ;
        d.rd        = instr[11:7];
        d.rd_we     = 1'b1;
        d.imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OpLui, OpAuipc: begin
        legal       = 1'b1;
        d.fmt       = FmtU;
        d.rd        = instr[11:7];
        d.rd_we     = 1'b1;
        d.imm[31:0] = {instr[31:12], 12'h000};
      end
      default: legal = 1'b0;
    endcase
    d.rd_we = d.rd_we && (d.rd != 5'd0);
    if (!legal) begin
      d         = '0;
      d.opcode  = instr[6:0];
      d.pc      = pc;
      d.fmt     = FmtNone;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  dec_t             out_q;
  dec_t             skid_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic [CNT_W-1:0] cnt_q;
  dec_t             dec;
  logic             accept;
  logic             out_free;

  assign dec      = decode(dec_if.in_instr, dec_if.in_pc);
  assign accept   = dec_if.in_valid && dec_if.in_ready;
  assign out_free = !out_valid_q || dec_if.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (out_valid_q && dec_if.out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (dec_if.flush) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (out_free) begin
        // in_ready is low whenever the skid is occupied, so no input competes with it here.
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= accept;
          if (accept) begin
            out_q <= dec;
          end
        end
      end else if (accept) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign dec_if.in_ready     = !rst && !skid_valid_q;
  assign dec_if.out_valid    = out_valid_q;
  assign dec_if.out_pc       = out_q.pc;
  assign dec_if.opcode       = out_q.opcode;
  assign dec_if.func3        = out_q.func3;
  assign dec_if.func7        = out_q.func7;
  assign dec_if.rs1          = out_q.rs1;
  assign dec_if.rs2          = out_q.rs2;
  assign dec_if.rd           = out_q.rd;
  assign dec_if.imm          = out_q.imm;
  assign dec_if.fmt          = out_q.fmt;
  assign dec_if.mem_size     = out_q.mem_size;
  assign dec_if.mem_unsigned = out_q.mem_unsigned;
  assign dec_if.rd_we        = out_q.rd_we;
  assign dec_if.illegal      = out_q.illegal;
  assign dec_if.decode_count = cnt_q;

endmodule
